// File: rtl/key_tone_generator_if.sv
// Key-code in / tone-out bundle between the key encoder, tone generator and audio pin.
// With KEY_TONE_MUTE_EN defined, the bundle also carries the mute input.
interface key_tone_if;
  logic [4:0] key_code;
  logic       tone_out;
  logic       note_active;
  logic [4:0] cur_code;
`ifdef KEY_TONE_MUTE_EN
  logic       mute;

  modport master (output key_code, output mute, input tone_out, input note_active, input cur_code);
  modport slave  (input key_code, input mute, output tone_out, output note_active, output cur_code);
`else
  modport master (output key_code, input tone_out, input note_active, input cur_code);
  modport slave  (input key_code, output tone_out, output note_active, output cur_code);
`endif
endinterface

// File: rtl/key_tone_generator.sv
// Glitch-filtered key code drives a SILENT/PLAYING/RELEASE note FSM and a square-wave tone.
// Optional KEY_TONE_MUTE_EN adds a combinational mute on tone_out.
module key_tone_generator #(
  parameter int BASE_HALF      = 1000,
  parameter int STEP           = 40,
  parameter int HOLD_CYCLES    = 4,
  parameter int RELEASE_CYCLES = 2000
) (
  input logic     clk,
  input logic     rst_n,
  key_tone_if.slave kif
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_L = CW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REL_L  = RW'(RELEASE_CYCLES);
  localparam logic [15:0]   BASE_L = 16'(BASE_HALF);
  localparam logic [15:0]   STEP_L = 16'(STEP);

  typedef enum logic [1:0] {SILENT, PLAYING, RELEASE} state_t;

  logic [4:0]    s, cand, acc_code;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          acc, acc_nxt;

  assign s = (kif.key_code > 5'd21) ? 5'd0 : kif.key_code;

  always_comb begin
    cnt_nxt = (s != cand) ? CW'(1) : ((cnt == HOLD_L) ? cnt : cnt + CW'(1));
    // Re-arm also covers HOLD_CYCLES==1, where a fresh code reaches the target immediately.
    acc_nxt = (cnt_nxt == HOLD_L) && ((s != cand) || (cnt != HOLD_L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      acc_code <= '0;
    end else begin
      cand     <= s;
      cnt      <= cnt_nxt;
      acc      <= acc_nxt;
      acc_code <= s;
    end
  end

  state_t        state, state_d;
  logic          tone, tone_d;
  logic [4:0]    code, code_d, pend, pend_d;
  logic          pend_vld, pend_vld_d;
  logic [15:0]   half_cnt, half_d, half;
  logic [RW-1:0] rel_cnt, rel_d;
  logic          toggle, rel_sat, acc_nz, acc_rel, acc_new;

  assign half    = BASE_L - 16'(code) * STEP_L;
  assign toggle  = (half_cnt == half - 16'd1);
  assign rel_sat = (rel_cnt == REL_L);
  assign acc_nz  = acc && (acc_code != 5'd0);
  assign acc_rel = acc && (acc_code == 5'd0);
  assign acc_new = acc_nz && (acc_code != code);

  always_comb begin
    state_d    = state;
    tone_d     = tone;
    code_d     = code;
    half_d     = half_cnt;
    rel_d      = rel_cnt;
    pend_d     = pend;
    pend_vld_d = pend_vld;
    unique case (state)
      SILENT: begin
        if (acc_nz) begin
          state_d = PLAYING; code_d = acc_code; tone_d = 1'b1; half_d = '0; pend_vld_d = 1'b0;
        end
      end
      PLAYING: begin
        if (toggle) begin
          tone_d = ~tone;
          half_d = '0;
          // A code accepted on this very edge waits for the following toggle.
          if (pend_vld && !acc_rel && !acc_new) begin
            code_d     = pend;
            pend_vld_d = 1'b0;
          end
        end else begin
          half_d = half_cnt + 16'd1;
        end
        if (acc_rel) begin
          state_d = RELEASE; rel_d = '0; pend_d = '0; pend_vld_d = 1'b0;
        end else if (acc_new) begin
          pend_d = acc_code; pend_vld_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!rel_sat) rel_d = rel_cnt + RW'(1);
        if (acc_nz) begin
          state_d = PLAYING; code_d = acc_code; tone_d = 1'b1; half_d = '0; pend_vld_d = 1'b0;
        end else if (rel_sat && (!tone || toggle)) begin
          // Finish only on a falling edge so the last high phase is never cut short.
          state_d = SILENT; tone_d = 1'b0; code_d = '0; half_d = '0;
        end else if (toggle) begin
          tone_d = ~tone; half_d = '0;
        end else begin
          half_d = half_cnt + 16'd1;
        end
      end
      default: state_d = SILENT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SILENT;
      tone     <= 1'b0;
      code     <= '0;
      half_cnt <= '0;
      rel_cnt  <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      state    <= state_d;
      tone     <= tone_d;
      code     <= code_d;
      half_cnt <= half_d;
      rel_cnt  <= rel_d;
      pend     <= pend_d;
      pend_vld <= pend_vld_d;
    end
  end

`ifdef KEY_TONE_MUTE_EN
  assign kif.tone_out = tone & ~kif.mute;
`else
  assign kif.tone_out = tone;
`endif
  assign kif.note_active = (state == PLAYING);
  assign kif.cur_code    = code;
endmodule

// File: tb/tb_key_tone_generator.sv
// Scoreboard bench: a time-stamped reference model queues expected output changes,
// a negedge monitor pops and compares them whenever the DUT outputs change.
module tb_key_tone_generator;
  localparam int BASE_HALF = 1000, STEP = 40, HOLD = 4, REL = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_tone_if kif();
  key_tone_generator #(.BASE_HALF(BASE_HALF), .STEP(STEP), .HOLD_CYCLES(HOLD), .RELEASE_CYCLES(REL))
    dut (.clk(clk), .rst_n(rst_n), .kif(kif));

  typedef struct { int cyc; logic tone; logic note; logic [4:0] code; } ev_t;
  ev_t q[$];
  int checks = 0, errors = 0, cyc = 0;

  function automatic int half_of(int c);
    return BASE_HALF - c * STEP;
  endfunction

  // Reference model: tone edges are scheduled as absolute cycle numbers.
  int m_state, m_code, m_pend, m_next, m_rel_start, f_last, f_run, f_code, m_old, s_in;
  bit m_tone, f_acc, tog, a_nz, a_rel, a_new, o_tone, o_note, p_tone, p_note, mute_now;
  int p_code;

  always @(posedge clk) begin
    cyc++;
`ifdef KEY_TONE_MUTE_EN
    mute_now = kif.mute;
`else
    mute_now = 1'b0;
`endif
    if (!rst_n) begin
      m_state = 0; m_tone = 0; m_code = 0; m_pend = 0; m_next = 0; m_rel_start = 0;
      f_last = 0; f_run = 0; f_acc = 0; f_code = 0;
      p_tone = 0; p_note = 0; p_code = 0;
    end else begin
      tog   = (m_state != 0) && (cyc == m_next);
      a_nz  = f_acc && f_code != 0;
      a_rel = f_acc && f_code == 0;
      m_old = m_code;
      a_new = a_nz && f_code != m_old;
      case (m_state)
        0: if (a_nz) begin
             m_state = 1; m_code = f_code; m_tone = 1; m_pend = 0; m_next = cyc + half_of(f_code);
           end
        1: begin
             if (tog) begin
               m_tone = !m_tone;
               if (m_pend != 0 && !a_rel && !a_new) begin m_code = m_pend; m_pend = 0; end
               m_next = cyc + half_of(m_code);
             end
             if (a_rel) begin m_state = 2; m_rel_start = cyc; m_pend = 0; end
             else if (a_new) m_pend = f_code;
           end
        default: begin
             if (a_nz) begin
               m_state = 1; m_code = f_code; m_tone = 1; m_pend = 0; m_next = cyc + half_of(f_code);
             end else if ((cyc - m_rel_start) > REL && (!m_tone || tog)) begin
               m_state = 0; m_tone = 0; m_code = 0;
             end else if (tog) begin
               m_tone = !m_tone; m_next = cyc + half_of(m_code);
             end
           end
      endcase
      s_in = (int'(kif.key_code) > 21) ? 0 : int'(kif.key_code);
      if (s_in == f_last) begin if (f_run < 1000000) f_run++; end
      else begin f_last = s_in; f_run = 1; end
      f_acc  = (f_run == HOLD);
      f_code = s_in;
      o_tone = m_tone & !mute_now;
      o_note = (m_state == 1);
      if (o_tone != p_tone || o_note != p_note || m_code != p_code) begin
        q.push_back('{cyc, o_tone, o_note, 5'(m_code)});
        p_tone = o_tone; p_note = o_note; p_code = m_code;
      end
    end
  end

  logic d_tone = 1'b0, d_note = 1'b0;
  logic [4:0] d_code = '0;
  ev_t ev;

  always @(negedge clk) begin
    if (!rst_n) begin
      d_tone = 0; d_note = 0; d_code = 0;
    end else if (kif.tone_out !== d_tone || kif.note_active !== d_note || kif.cur_code !== d_code) begin
      d_tone = kif.tone_out; d_note = kif.note_active; d_code = kif.cur_code;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got tone=%b note=%b code=%0d, required no change",
                 cyc, d_tone, d_note, d_code);
      end else begin
        ev = q.pop_front();
        if (ev.cyc != cyc || ev.tone !== d_tone || ev.note !== d_note || ev.code !== d_code) begin
          errors++;
          $display("FAIL output_event got cyc=%0d tone=%b note=%b code=%0d, required cyc=%0d tone=%b note=%b code=%0d",
                   cyc, d_tone, d_note, d_code, ev.cyc, ev.tone, ev.note, ev.code);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input int code, input int n, input bit m);
    @(negedge clk);
    #1;
    kif.key_code = 5'(code);
`ifdef KEY_TONE_MUTE_EN
    kif.mute = m;
`else
    if (m) kif.key_code = 5'(code);
`endif
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tone"}, int'(kif.tone_out), 0);
    check({tag, "_note"}, int'(kif.note_active), 0);
    check({tag, "_code"}, int'(kif.cur_code), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int code, len, r, waited;
    bit m;
    kif.key_code = '0;
`ifdef KEY_TONE_MUTE_EN
    kif.mute = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_idle("reset");
    #1 rst_n = 1'b1;

    drive(5, 2500, 0);            // accept latency and 800/800 square wave
    drive(21, 1200, 0);           // code change lands on a toggle
    drive(5, 1000, 0);
    drive(0, 3500, 0);            // release tail then stop on a falling edge
    check_idle("released");
    drive(3, 2, 0);               // too short to be accepted
    drive(0, 50, 0);
    check_idle("glitch");
    drive(25, 100, 0);            // out-of-range code behaves as no key
    check_idle("invalid");
`ifdef KEY_TONE_MUTE_EN
    drive(5, 1000, 0);
    drive(5, 300, 1);
    drive(5, 500, 0);
`endif
    for (int i = 0; i < 30; i++) begin
      r    = $urandom_range(0, 9);
      code = (r < 2) ? 0 : (r < 3) ? int'($urandom_range(22, 31)) : int'($urandom_range(1, 21));
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(20, 1200));
      m    = ($urandom_range(0, 4) == 0);
      drive(code, len, m);
    end

    drive(0, 3200, 0);
    drive(7, 1, 0);
    waited = 0;
    while (kif.tone_out !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("tone_start_timeout", int'(waited < 3000), 1);
    repeat (100) @(negedge clk);
    check("pre_reset_code", int'(kif.cur_code), 7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle("async_reset");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    drive(0, 20, 0);

    check("queue_drained", q.size(), 0);
    if (q.size() != 0) $display("FAIL leftover events=%0d required=0", q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
